// File: rtl/fetch_queue_pkg.sv
// Shared constants and the queued entry layout for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pcPlus4;
        logic [31:0] instruction;
    } entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular entry store with head/tail pointers and occupancy count; flush empties it.
// Latency: a push is visible at headData the cycle after; caller must not push when full or pop when empty.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  entry_t        pushData,
    input  logic          pop,
    input  logic          flush,
    output entry_t        headData,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;

    // Storage carries no reset; validity is derived from count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tailPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign headData = mem[headPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential fetch PC, memory request, redirect flush, registered head output.
// Latency: fetched word reaches the outputs one cycle after acceptance; requests stop when full, hold stalls the head.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = fetch_queue_pkg::DEPTH,
    parameter logic [31:0] RESET_PC = fetch_queue_pkg::RESET_PC,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    output logic [31:0]   imem_addr,
    output logic          imem_req,
    input  logic          imem_ready,
    input  logic [31:0]   imem_data,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          hold,
    output logic          out_valid,
    output logic [31:0]   out_instruction,
    output logic [31:0]   out_pc_plus4,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]   WORD_MASK  = 32'hFFFF_FFFC;

    logic [31:0] fetchPc;
    logic        doPush;
    logic        doPop;
    logic        headValid;
    entry_t      pushEntry;
    entry_t      headEntry;

    assign imem_req  = (count != FULL_COUNT) && !redirect;
    assign doPush    = imem_req && imem_ready;
    assign headValid = (count != '0);
    // Redirect outranks hold and pop so nothing stale leaves the queue in the flush cycle.
    assign doPop     = headValid && !hold && !redirect;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPc <= RESET_PC & WORD_MASK;
        end else if (redirect) begin
            fetchPc <= redirect_pc & WORD_MASK;
        end else if (doPush) begin
            fetchPc <= fetchPc + 32'd4;
        end
    end

    assign imem_addr = fetchPc;

    always_comb begin
        pushEntry             = '0;
        pushEntry.pcPlus4     = fetchPc + 32'd4;
        pushEntry.instruction = imem_data;
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (doPush),
        .pushData (pushEntry),
        .pop      (doPop),
        .flush    (redirect),
        .headData (headEntry),
        .count    (count)
    );

    assign out_valid       = headValid;
    assign out_instruction = headValid ? headEntry.instruction : NOP;
    assign out_pc_plus4    = headValid ? headEntry.pcPlus4 : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table for the directed flow, scoreboard model checked every cycle.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_plus4;
    logic [2:0]  count;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_ready      (imem_ready),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .hold            (hold),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc_plus4    (out_pc_plus4),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        hld;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] eAddr;
        logic        eReq;
        logic [2:0]  eCnt;
        logic        eVld;
        logic [31:0] ePc4;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] modelPc;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[21];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic d, input logic [31:0] rpc);
        imem_ready  = r;
        hold        = h;
        redirect    = d;
        redirect_pc = rpc;
        imem_data   = memWord(modelPc);
    endtask

    task automatic checkModel();
        logic        eV;
        logic [31:0] eI;
        logic [31:0] eP;
        eV = (sb.size() != 0);
        eI = eV ? sb[0].instr : 32'h0;
        eP = eV ? sb[0].pc4 : 32'h0;
        chk("imem_addr", imem_addr, modelPc);
        chk("imem_req", imem_req, (sb.size() != 4) && !redirect);
        chk("count", count, sb.size());
        chk("out_valid", out_valid, eV);
        chk("out_instruction", out_instruction, eI);
        chk("out_pc_plus4", out_pc_plus4, eP);
    endtask

    task automatic advance();
        logic req;
        logic pu;
        logic po;
        exp_t e;
        req = (sb.size() != 4) && !redirect;
        pu  = req && imem_ready;
        po  = (sb.size() != 0) && !hold && !redirect;
        if (redirect) begin
            sb.delete();
            modelPc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) begin
                e.pc4   = modelPc + 32'd4;
                e.instr = memWord(modelPc);
                sb.push_back(e);
                modelPc = modelPc + 32'd4;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic r, input logic h, input logic d, input logic [31:0] rpc);
        drive(r, h, d, rpc);
        #4;
        checkModel();
        advance();
    endtask

    initial begin
        // Sequential fetch, restart at 0, hold until full, drain, redirect to 0x43, ready toggling.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h00, 1'b1, 3'd0, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 3'd1, 1'b1, 32'h04};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 3'd1, 1'b1, 32'h08};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h0C, 1'b0, 3'd1, 1'b1, 32'h0C};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h00, 1'b1, 3'd0, 1'b0, 32'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h04, 1'b1, 3'd1, 1'b1, 32'h04};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h08, 1'b1, 3'd2, 1'b1, 32'h04};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0C, 1'b1, 3'd3, 1'b1, 32'h04};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h10, 1'b0, 3'd4, 1'b1, 32'h04};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h10, 1'b0, 3'd4, 1'b1, 32'h04};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h10, 1'b0, 3'd4, 1'b1, 32'h04};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h10, 1'b1, 3'd3, 1'b1, 32'h08};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h14, 1'b1, 3'd3, 1'b1, 32'h0C};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h18, 1'b1, 3'd3, 1'b1, 32'h10};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h43, 32'h1C, 1'b0, 3'd3, 1'b1, 32'h14};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 1'b1, 3'd0, 1'b0, 32'h00};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h44, 1'b1, 3'd1, 1'b1, 32'h44};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h44, 1'b1, 3'd0, 1'b0, 32'h00};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h48, 1'b1, 3'd1, 1'b1, 32'h48};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h48, 1'b1, 3'd0, 1'b0, 32'h00};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h4C, 1'b1, 3'd1, 1'b1, 32'h4C};

        reset       = 1'b0;
        imem_ready  = 1'b1;
        imem_data   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        hold        = 1'b0;
        modelPc     = 32'h0;

        #8;
        chk("reset_count", count, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_instr", out_instruction, 0);
        chk("reset_pc4", out_pc_plus4, 0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_req", imem_req, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rdy, tbl[i].hld, tbl[i].rdr, tbl[i].rpc);
            #4;
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eAddr);
            chk($sformatf("vec%0d_req", i), imem_req, tbl[i].eReq);
            chk($sformatf("vec%0d_count", i), count, tbl[i].eCnt);
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].eVld);
            chk($sformatf("vec%0d_pc4", i), out_pc_plus4, tbl[i].ePc4);
            checkModel();
            advance();
        end

        // Fill the queue, then redirect together with hold.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        #4;
        chk("full_count", count, 4);
        chk("full_req", imem_req, 0);
        checkModel();
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #4;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_addr", imem_addr, 32'h100);
        checkModel();
        advance();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Back-to-back redirects: the second target wins.
        step(1'b1, 1'b0, 1'b1, 32'h200);
        step(1'b1, 1'b0, 1'b1, 32'h307);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #4;
        chk("b2b_addr", imem_addr, 32'h304);
        chk("b2b_count", count, 0);
        checkModel();
        advance();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0), $urandom);
        end

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 1'b0, 1'b1, 32'h500);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        chk("prereset_count", count, 2);
        reset = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_instr", out_instruction, 0);
        chk("arst_pc4", out_pc_plus4, 0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_req", imem_req, 1);
        sb.delete();
        modelPc = 32'h0;
        @(posedge clock);
        #1;
        chk("arst_hold_count", count, 0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #4;
        chk("restart_addr", imem_addr, 32'h0);
        checkModel();
        advance();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
